// File: rtl/register_32bits.sv
// General-purpose clocked data register with synchronous active-low reset and one cycle of latency.
// Optional even-parity output out_par when REGISTER_32BITS_PARITY_EN is defined.
module register_32bits #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] in,
`ifdef REGISTER_32BITS_PARITY_EN
    output logic             out_par,
`endif
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] out_next;

    // Each bit is its own flop; bit i of in lands on bit i of out with no reordering.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_comb begin
                out_next[gi] = in[gi];
            end

            always_ff @(posedge Clk) begin
                if (!Rst_n) begin
                    out_reg[gi] <= RESET_VALUE[gi];
                end else begin
                    out_reg[gi] <= out_next[gi];
                end
            end
        end
    endgenerate

    assign out = out_reg;

`ifdef REGISTER_32BITS_PARITY_EN
    logic par_reg;
    logic par_next;

    // Parity is computed from in, not out, so it settles in the same flop stage as the data.
    always_comb begin
        par_next = ^in;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            par_reg <= ^RESET_VALUE;
        end else begin
            par_reg <= par_next;
        end
    end

    assign out_par = par_reg;
`endif

endmodule

// File: tb/tb_register_32bits.sv
// Directed testbench for register_32bits: reset, latency, mid-cycle changes, bit mapping, optional parity.
module tb_register_32bits;

    logic        clk;
    logic        rst_n;
    logic [31:0] din;
    logic [31:0] dout;
`ifdef REGISTER_32BITS_PARITY_EN
    logic        dpar;
`endif

    int vectors;
    int errors;

    register_32bits #(
        .WIDTH       (32),
        .RESET_VALUE (32'h0000_0000)
    ) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .in    (din),
`ifdef REGISTER_32BITS_PARITY_EN
        .out_par (dpar),
`endif
        .out   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("vec %0d %s out=%h exp=%h", vectors, tag, obs, exp);
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0;
        errors  = 0;

        // Reset held for two edges with all-ones on the data input
        rst_n = 1'b0;
        din   = 32'hFFFF_FFFF;
        edge_sample();
        check("reset_edge1", dout, 32'h0000_0000);
`ifdef REGISTER_32BITS_PARITY_EN
        check("reset_par", {31'b0, dpar}, 32'h0);
`endif
        edge_sample();
        check("reset_edge2", dout, 32'h0000_0000);

        // Release reset mid-cycle; output holds until the edge
        @(negedge clk);
        rst_n = 1'b1;
        din   = 32'hDCFF_FFFF;
        #1;
        check("pre_edge_hold", dout, 32'h0000_0000);
        edge_sample();
        check("first_data", dout, 32'hDCFF_FFFF);

        // Back-to-back data with one-cycle lag
        @(negedge clk);
        din = 32'h0000_0001;
        edge_sample();
        check("b2b_0", dout, 32'h0000_0001);
        @(negedge clk);
        din = 32'h8000_0000;
        #1;
        check("b2b_0_hold", dout, 32'h0000_0001);
        edge_sample();
        check("b2b_1", dout, 32'h8000_0000);
        @(negedge clk);
        din = 32'hA5A5_A5A5;
        edge_sample();
        check("b2b_2", dout, 32'hA5A5_A5A5);

        // Input glitches between edges never reach the output
        @(negedge clk);
        din = 32'hAAAA_AAAA;
        #1 din = 32'h5555_5555;
        #1 din = 32'h0000_0000;
        #1 din = 32'h1234_5678;
        check("glitch_hold", dout, 32'hA5A5_A5A5);
        edge_sample();
        check("glitch_final", dout, 32'h1234_5678);

        // Mid-cycle reset assertion and release
        @(negedge clk);
        din = 32'hDEAD_BEEF;
        edge_sample();
        check("deadbeef", dout, 32'hDEAD_BEEF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_hold", dout, 32'hDEAD_BEEF);
        edge_sample();
        check("rst_mid_clear", dout, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        din   = 32'h0000_CAFE;
        #1;
        check("rel_mid_hold", dout, 32'h0000_0000);
        edge_sample();
        check("rel_mid_load", dout, 32'h0000_CAFE);

        // Walking one confirms bit-for-bit mapping
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            din = 32'h0000_0001 << i;
            edge_sample();
            check($sformatf("walk1_%0d", i), dout, 32'h0000_0001 << i);
        end

`ifdef REGISTER_32BITS_PARITY_EN
        @(negedge clk);
        din = 32'h0000_0007;
        edge_sample();
        check("par_odd", {31'b0, dpar}, 32'h1);
        @(negedge clk);
        din = 32'h0000_0003;
        edge_sample();
        check("par_even", {31'b0, dpar}, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        din   = 32'h0000_0001;
        edge_sample();
        check("par_in_reset", {31'b0, dpar}, 32'h0);
        rst_n = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
